uncache_arbiter: RTL and testbench
==================================

Name: uncache_arbiter

Overview:
- Owns the single uncached memory channel in the LSU and shares it between two requesters: the load read buffer (read) and the store write buffer (posted write).
- Runs one transaction at a time. Picks the winner by address hazard, then read priority, then a write-starvation limit.
- Latches the winning request and drives it onto the memory port until the memory accepts it.
- Returns read data through a registered valid/ready handshake.

Parameters:
- STARVE_LIMIT, 4: number of consecutive read grants allowed while a write is waiting; at the limit the write is forced through.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request accepted
- rd_addr  in  ADDR_W  read byte address
- rd_size  in  2  read size, lsu_size_t
- rd_rvalid  out  1  read data valid to requester
- rd_rdata  out  32  read data, unshifted memory word
- rd_rready  in  1  requester takes read data
- wr_valid  in  1  write request valid
- wr_ready  out  1  write request accepted
- wr_addr  in  ADDR_W  write byte address
- wr_data  in  32  write data, already lane-aligned
- wr_size  in  2  write size, lsu_size_t
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_wen  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  request address
- mem_data  out  32  write data
- mem_size  out  3  AXI-style size: word 3'b010, half 3'b001, byte 3'b000
- mem_strobe  out  4  byte strobe
- mem_rvalid  in  1  read response valid
- mem_rdata  in  32  read response data
- mem_rready  out  1  arbiter accepts read response
- busy  out  1  state is not IDLE

Behaviour:
- Reset:
  - asynchronous on resetn = 0; state goes to IDLE and starve_cnt to 0.
  - Every output resets to 0. A transaction in progress at reset is abandoned and is not replayed.
- FSM states: IDLE, REQ, RD_WAIT, RD_HOLD.
- Grant (combinational, IDLE only):
  - hazard = rd_valid & wr_valid & (rd_addr[ADDR_W-1:2] == wr_addr[ADDR_W-1:2]).
  - Grant write if wr_valid & (!rd_valid | hazard | starve_cnt == STARVE_LIMIT); otherwise grant read if rd_valid.
  - rd_ready and wr_ready are high only in IDLE for the granted side, and never both in the same cycle.
- On an accept handshake (cycle N):
  - latch addr, data, size and wen into the request registers;
  - next state is REQ; mem_valid is high from N+1.
- REQ:
  - mem_* is driven from the request registers and held stable until mem_valid & mem_ready.
  - Write handshake → IDLE (posted, no response).
  - Read handshake → RD_WAIT.
- RD_WAIT:
  - mem_rready = 1; mem_rready is 0 in every other state.
  - On mem_rvalid: register mem_rdata into rd_rdata, set rd_rvalid, go to RD_HOLD.
  - mem_rvalid outside RD_WAIT is ignored.
- RD_HOLD:
  - rd_rvalid is held with rd_rdata stable until rd_rready; then rd_rvalid clears and the state goes to IDLE.
  - Minimum gap between read grants is 4 cycles.
- starve_cnt (saturating at STARVE_LIMIT):
  - increments on a read grant while wr_valid = 1;
  - clears on a write grant, or in any IDLE cycle with wr_valid = 0.
- Size mapping (mem_size):
  - word → 3'b010, half → 3'b001, byte → 3'b000;
  - an illegal encoding maps to 3'b010.
- Strobe (mem_strobe):
  - word → 4'hf;
  - half → addr[1] ? 4'hc : 4'h3;
  - byte → 4'b0001 << addr[1:0];
  - reads also drive the computed strobe.
- Boundary cases:
  - rd_valid and wr_valid both asserted with no hazard → read first.
  - A requester dropping valid without a grant is legal.
  - mem_ready may be held high permanently; a one-cycle REQ is valid.

Decomposition:
- lsu_pkg: lsu_size_t (s_byte, s_half, s_word), the size→AXI-size function and the size/addr→strobe function, shared with the buffers.
- Optional sub-module uncache_req_reg: the request latch plus size/strobe encode.

Test Plan:
- Read only, from IDLE: rd_valid, addr 0x1FD0_F010, word; mem_ready = 1 at N+1; mem_rvalid at N+3 with 0xDEADBEEF; rd_rready = 1 → mem_valid only at N+1, mem_size 010, strobe f; rd_rvalid at N+4 with 0xDEADBEEF; busy clears at N+5.
- Hazard:
  - Stimulus: rd_valid and wr_valid in the same cycle; wr_addr 0x1FD0_F003 byte, rd_addr 0x1FD0_F000.
  - Response: write granted first with mem_wen 1 and strobe 8; the read is issued only after the write handshake.
- Starvation: rd_valid and wr_valid held continuously with distinct addresses and STARVE_LIMIT = 4 → grant order R, R, R, R, W.
- Backpressure:
  - Stimulus: mem_ready held low for 5 cycles in REQ, and rd_rready held low for 3 cycles in RD_HOLD.
  - Response: mem_* and rd_rdata stay stable throughout; there are no extra grants.
- Reset mid-operation: resetn low in RD_WAIT → all outputs 0 immediately; after release, a new request follows the normal latency.
- Half store at 0x...2: mem_size 001, strobe c; wr_ready is 0 in every non-IDLE state.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU types and encode helpers for the uncached path and the buffers.
//   lsu_size_t    : access size as carried by the load/store buffers
//   lsu_axi_size  : size -> AXI-style 3-bit size (illegal encoding -> word)
//   lsu_strobe    : size + low address bits -> 4-bit byte strobe
package lsu_pkg;

  typedef enum logic [1:0] {
    s_byte = 2'b00,
    s_half = 2'b01,
    s_word = 2'b10
  } lsu_size_t;

  localparam logic [2:0] AXI_SIZE_BYTE = 3'b000;
  localparam logic [2:0] AXI_SIZE_HALF = 3'b001;
  localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

  function automatic logic [2:0] lsu_axi_size(input lsu_size_t size);
    case (size)
      s_byte:  return AXI_SIZE_BYTE;
      s_half:  return AXI_SIZE_HALF;
      s_word:  return AXI_SIZE_WORD;
      default: return AXI_SIZE_WORD;
    endcase
  endfunction

  function automatic logic [3:0] lsu_strobe(input lsu_size_t size, input logic [1:0] addr_lo);
    case (size)
      s_byte:  return 4'b0001 << addr_lo;
      s_half:  return addr_lo[1] ? 4'hc : 4'h3;
      default: return 4'hf;
    endcase
  endfunction

endpackage

// File: rtl/uncache_req_reg.sv
// Request latch for the uncached channel. On load, captures the selected
// requester's address/data/size and the direction, and registers the
// encoded AXI size and byte strobe so the memory port is driven straight
// from flops.
//   clk, resetn        : clock, async active-low reset
//   load, sel_wr       : capture strobe; 1 selects the write requester
//   rd_addr, rd_size   : read request fields
//   wr_addr, wr_data, wr_size : write request fields
//   mem_wen, mem_addr, mem_data, mem_size, mem_strobe : latched request
module uncache_req_reg
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              sel_wr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_size,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [1:0]        wr_size,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic [2:0]        mem_size,
  output logic [3:0]        mem_strobe
);

  logic [ADDR_W-1:0] sel_addr;
  lsu_size_t         sel_size;

  always_comb begin
    sel_addr = sel_wr ? wr_addr : rd_addr;
    sel_size = lsu_size_t'(sel_wr ? wr_size : rd_size);
  end

  // Size and strobe are encoded before the latch so that the reset value of
  // every memory-port output is 0 rather than the byte-size encode of 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_size   <= '0;
      mem_strobe <= '0;
    end else if (load) begin
      mem_wen    <= sel_wr;
      mem_addr   <= sel_addr;
      mem_data   <= sel_wr ? wr_data : '0;
      mem_size   <= lsu_axi_size(sel_size);
      mem_strobe <= lsu_strobe(sel_size, sel_addr[1:0]);
    end
  end

endmodule

// File: rtl/uncache_arbiter.sv
// Uncached memory channel arbiter: shares one memory port between the load
// read buffer (rd_*) and the store write buffer (wr_*, posted). One
// transaction at a time; grant priority is same-word hazard -> write, then
// read, with a write forced through after STARVE_LIMIT consecutive reads.
//   rd_valid/rd_ready/rd_addr/rd_size      : read request
//   rd_rvalid/rd_rdata/rd_rready           : registered read data return
//   wr_valid/wr_ready/wr_addr/wr_data/wr_size : write request
//   mem_valid/mem_ready/mem_wen/mem_addr/mem_data/mem_size/mem_strobe : request
//   mem_rvalid/mem_rdata/mem_rready        : memory read response
//   busy                                   : a transaction is in flight
module uncache_arbiter
  import lsu_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_size,
  output logic              rd_rvalid,
  output logic [31:0]       rd_rdata,
  input  logic              rd_rready,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [1:0]        wr_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic [2:0]        mem_size,
  output logic [3:0]        mem_strobe,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              mem_rready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RD_WAIT = 2'd2,
    RD_HOLD = 2'd3
  } state_t;

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             hazard;
  logic             starved;
  logic             grant_wr;
  logic             grant_rd;
  logic             load;

  // A read to the same word as a pending write must observe the write, so
  // the write goes first.
  assign hazard   = rd_valid & wr_valid & (rd_addr[ADDR_W-1:2] == wr_addr[ADDR_W-1:2]);
  assign starved  = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_wr = wr_valid & (~rd_valid | hazard | starved);
  assign grant_rd = rd_valid & ~grant_wr;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rd_ready   = 1'b0;
    wr_ready   = 1'b0;
    mem_valid  = 1'b0;
    mem_rready = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = grant_wr;
        rd_ready = grant_rd;
        if (grant_wr | grant_rd) begin
          load      = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_valid = 1'b1;
        if (mem_ready) state_nxt = mem_wen ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        mem_rready = 1'b1;
        if (mem_rvalid) state_nxt = RD_HOLD;
      end
      RD_HOLD: begin
        if (rd_rready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  uncache_req_reg #(
    .ADDR_W(ADDR_W)
  ) u_req_reg (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .sel_wr    (grant_wr),
    .rd_addr   (rd_addr),
    .rd_size   (rd_size),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_size   (wr_size),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_size  (mem_size),
    .mem_strobe(mem_strobe)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_rvalid <= 1'b0;
      rd_rdata  <= '0;
    end else if (state == RD_WAIT && mem_rvalid) begin
      rd_rvalid <= 1'b1;
      rd_rdata  <= mem_rdata;
    end else if (state == RD_HOLD && rd_rready) begin
      rd_rvalid <= 1'b0;
    end
  end

  // Counts reads granted over a waiting write; any IDLE cycle without a
  // write pending means nobody is starving.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_wr || !wr_valid)      starve_cnt <= '0;
      else if (grant_rd && !starved)  starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uncache_arbiter.sv
module tb_uncache_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        rd_valid = 0, rd_rready = 0, wr_valid = 0;
  logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0, mem_rdata = '0;
  logic [1:0]  rd_size = '0, wr_size = '0;
  logic        mem_ready = 0, mem_rvalid = 0;
  logic        rd_ready, rd_rvalid, wr_ready, mem_valid, mem_wen, mem_rready, busy;
  logic [31:0] rd_rdata, mem_addr, mem_data;
  logic [2:0]  mem_size;
  logic [3:0]  mem_strobe;

  always #5 clk = ~clk;

  uncache_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_size(rd_size),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .rd_rready(rd_rready),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_size(wr_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_size(mem_size), .mem_strobe(mem_strobe),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: at most one open transaction, described by
  // whether memory took it yet and whether read data is being offered.
  bit          m_open, m_issued, m_have;
  bit          m_wr;
  logic [31:0] m_addr, m_data, m_rdata;
  logic [1:0]  m_size;
  int          m_cnt;
  int          dut_grant;   // 0 none, 1 read, 2 write (observed this cycle)

  function automatic logic [2:0] ref_axi(input logic [1:0] s);
    if (s == 2'd0) return 3'd0;
    if (s == 2'd1) return 3'd1;
    return 3'd2;
  endfunction

  function automatic logic [3:0] ref_strobe(input logic [1:0] s, input logic [1:0] a);
    if (s == 2'd0) return 4'd1 << a;
    if (s == 2'd1) return 4'b0011 << (a & 2'b10);
    return 4'hf;
  endfunction

  function automatic bit ref_wr_wins();
    return wr_valid && (!rd_valid || ((rd_addr >> 2) == (wr_addr >> 2)) || m_cnt >= LIMIT);
  endfunction

  task automatic model_reset();
    m_open = 0; m_issued = 0; m_have = 0; m_cnt = 0;
  endtask

  task automatic compare();
    bit e_wg, e_rg;
    e_wg = !m_open && ref_wr_wins();
    e_rg = !m_open && rd_valid && !e_wg;
    chk("busy", busy, m_open);
    chk("rd_ready", rd_ready, e_rg);
    chk("wr_ready", wr_ready, e_wg);
    chk("rdy_excl", rd_ready & wr_ready, 0);
    chk("mem_valid", mem_valid, m_open && !m_issued);
    chk("mem_rready", mem_rready, m_open && m_issued && !m_wr && !m_have);
    chk("rd_rvalid", rd_rvalid, m_have);
    if (m_open && !m_issued) begin
      chk("mem_wen", mem_wen, m_wr);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_size", mem_size, ref_axi(m_size));
      chk("mem_strobe", mem_strobe, ref_strobe(m_size, m_addr[1:0]));
      if (m_wr) chk("mem_data", mem_data, m_data);
    end
    if (m_have) chk("rd_rdata", rd_rdata, m_rdata);
  endtask

  task automatic model_update();
    if (!m_open) begin
      if (ref_wr_wins()) begin
        m_wr = 1; m_addr = wr_addr; m_data = wr_data; m_size = wr_size;
        m_open = 1; m_issued = 0; m_cnt = 0;
      end else if (rd_valid) begin
        m_wr = 0; m_addr = rd_addr; m_data = '0; m_size = rd_size;
        m_open = 1; m_issued = 0;
        m_cnt = wr_valid ? ((m_cnt < LIMIT) ? m_cnt + 1 : m_cnt) : 0;
      end else begin
        m_cnt = 0;
      end
    end else if (!m_issued) begin
      if (mem_ready) begin
        m_issued = 1;
        if (m_wr) m_open = 0;
      end
    end else if (!m_have) begin
      if (mem_rvalid) begin
        m_have = 1; m_rdata = mem_rdata;
      end
    end else if (rd_rready) begin
      m_have = 0; m_open = 0;
    end
  endtask

  // One clock cycle: inputs already set at posedge+1; check, advance model.
  task automatic step();
    #1;
    compare();
    dut_grant = (rd_ready && rd_valid) ? 1 : (wr_ready && wr_valid) ? 2 : 0;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rd_ready"}, rd_ready, 0);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_mem_rready"}, mem_rready, 0);
    chk({tag, "_rd_rvalid"}, rd_rvalid, 0);
    chk({tag, "_rd_rdata"}, rd_rdata, 0);
    chk({tag, "_mem_wen"}, mem_wen, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_data"}, mem_data, 0);
    chk({tag, "_mem_size"}, mem_size, 0);
    chk({tag, "_mem_strobe"}, mem_strobe, 0);
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] size, input int rdy_dly, input int rv_dly,
                        input int rr_dly);
    bit got;
    got = 0;
    if (wr) begin wr_valid = 1; wr_addr = addr; wr_data = data; wr_size = size; end
    else    begin rd_valid = 1; rd_addr = addr; rd_size = size; end
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = (dut_grant == (wr ? 2 : 1));
    end
    chk("grant_wait", got, 1);
    rd_valid = 0; wr_valid = 0;
    if (!got) return;
    repeat (rdy_dly) step();
    mem_ready = 1; step(); mem_ready = 0;
    if (!wr) begin
      repeat (rv_dly) step();
      mem_rvalid = 1; mem_rdata = data; step(); mem_rvalid = 0;
      repeat (rr_dly) step();
      rd_rready = 1; step(); rd_rready = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ord[$];
    int          exp_ord[10];
    int          extra;
    logic [31:0] pool[4];
    exp_ord = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    pool    = '{32'h1FD0_F000, 32'h1FD0_F002, 32'h1FD0_F004, 32'h1FD0_F107};

    // Reset state
    #1 resetn = 0;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    model_reset();
    step();

    // Plain read: grant N, mem_valid N+1, response N+3, rd_rvalid N+4
    do_txn(0, 32'h1FD0_F010, 32'hDEADBEEF, 2'd2, 0, 1, 0);
    chk("read_busy_clear", busy, 0);
    step();

    // Same-word hazard: write wins, read follows the write handshake
    rd_valid = 1; rd_addr = 32'h1FD0_F000; rd_size = 2'd2;
    wr_valid = 1; wr_addr = 32'h1FD0_F003; wr_size = 2'd0; wr_data = 32'hAA00_0000;
    step();
    chk("hz_first", dut_grant, 2);
    wr_valid = 0;
    chk("hz_wen", mem_wen, 1);
    chk("hz_strobe", mem_strobe, 4'h8);
    mem_ready = 1; step();
    chk("hz_no_early_read", dut_grant, 0);
    mem_ready = 0; step();
    chk("hz_second", dut_grant, 1);
    rd_valid = 0;
    mem_ready = 1; step(); mem_ready = 0;
    mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D; step(); mem_rvalid = 0;
    rd_rready = 1; step(); rd_rready = 0;
    step();

    // Starvation: both valid forever, distinct words
    rd_valid = 1; rd_addr = 32'h0000_0100; rd_size = 2'd2;
    wr_valid = 1; wr_addr = 32'h0000_0200; wr_size = 2'd2; wr_data = 32'h5555_AAAA;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h1357_9BDF; rd_rready = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (dut_grant != 0) ord.push_back(dut_grant);
    end
    rd_valid = 0; wr_valid = 0;
    repeat (6) step();
    mem_ready = 0; mem_rvalid = 0; rd_rready = 0;
    chk("starve_count", ord.size() >= 10, 1);
    for (int i = 0; i < 10 && i < ord.size(); i++)
      chk($sformatf("starve_order_%0d", i), ord[i], exp_ord[i]);
    step();

    // Backpressure: memory stalls 5 cycles, requester stalls 3; other side
    // keeps requesting with changing addresses and must not be granted.
    rd_valid = 1; rd_addr = 32'h1FD0_F024; rd_size = 2'd1;
    step();
    chk("bp_grant", dut_grant, 1);
    extra = 0;
    rd_addr = 32'h0000_0040; wr_valid = 1; wr_addr = 32'h0000_0080; wr_size = 2'd2;
    for (int i = 0; i < 5; i++) begin step(); if (dut_grant != 0) extra++; end
    mem_ready = 1; step(); mem_ready = 0;
    mem_rvalid = 1; mem_rdata = 32'hCAFE_0001; step(); mem_rvalid = 0;
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin step(); if (dut_grant != 0) extra++; end
    chk("bp_rdata_hold", rd_rdata, 32'hCAFE_0001);
    rd_valid = 0; wr_valid = 0;
    rd_rready = 1; step(); rd_rready = 0;
    chk("bp_extra_grants", extra, 0);
    step();

    // Half store at byte offset 2, write valid kept high through REQ
    wr_valid = 1; wr_addr = 32'h1FD0_F012; wr_size = 2'd1; wr_data = 32'h1234_0000;
    step();
    chk("hs_grant", dut_grant, 2);
    wr_addr = 32'h1FD0_F030;
    chk("hs_size", mem_size, 3'b001);
    chk("hs_strobe", mem_strobe, 4'hc);
    repeat (2) step();
    wr_valid = 0; mem_ready = 1; step(); mem_ready = 0;
    step();

    // Reset while waiting for read data
    rd_valid = 1; rd_addr = 32'h1FD0_F020; rd_size = 2'd2;
    step();
    rd_valid = 0; mem_ready = 1; step(); mem_ready = 0;
    chk("rst_in_rdwait", mem_rready, 1);
    #2 resetn = 0;
    #1 chk_all_zero("midrst");
    model_reset();
    @(posedge clk);
    #1 resetn = 1;
    do_txn(0, 32'h1FD0_F044, 32'h0F0F_A5A5, 2'd0, 0, 1, 0);
    step();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rd_valid   = ($urandom_range(0, 1) == 1);
      wr_valid   = ($urandom_range(0, 9) < 7);
      rd_addr    = pool[$urandom_range(0, 3)];
      wr_addr    = pool[$urandom_range(0, 3)];
      rd_size    = 2'($urandom_range(0, 3));
      wr_size    = 2'($urandom_range(0, 3));
      wr_data    = $urandom;
      mem_ready  = ($urandom_range(0, 2) != 0);
      mem_rvalid = ($urandom_range(0, 1) == 1);
      mem_rdata  = $urandom;
      rd_rready  = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
